// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the single write port of the pMIPS register file. After reset it
// zero-fills %2..%N-1 in a hardware sweep. It then shares the port between
// requester A (core writeback) and requester B (debug/loader) using
// valid/ready handshakes and round-robin arbitration. Writes aimed at %0
// (hardwired zero) or %1 (inport) complete their handshake but are discarded
// and counted.
module regfile_write_arbiter #(
  parameter int n              = 8,
  parameter int registers_size = 3
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic                      a_valid,
  input  logic [registers_size-1:0] a_addr,
  input  logic [n-1:0]              a_data,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [registers_size-1:0] b_addr,
  input  logic [n-1:0]              b_data,
  output logic                      b_ready,
  output logic                      w,
  output logic [registers_size-1:0] r_dest,
  output logic [n-1:0]              write_data,
  output logic                      init_busy,
  output logic [7:0]                drop_count
);

  typedef enum logic {INIT, ARB} state_t;
  typedef enum logic {GRANT_A, GRANT_B} grant_t;

  // The sweep starts at %2 and finishes at the highest address.
  localparam logic [registers_size-1:0] FIRST_ADDR = registers_size'(2);
  localparam logic [registers_size-1:0] LAST_ADDR  = '1;

  state_t                      state, state_next;
  grant_t                      last_grant;
  logic [registers_size-1:0]   init_addr;
  logic                        grant_a, grant_b;
  logic                        xfer, xfer_drop;
  logic [registers_size-1:0]   xfer_addr;
  logic [n-1:0]                xfer_data;

  // State register; reset always returns to the zero-fill sweep.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers sample pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= INIT;
    else         state <= state_next;
  end

  // Next state, round-robin grant and handshake readys.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    case (state)
      INIT: begin
        if (init_addr == LAST_ADDR) state_next = ARB;
      end
      ARB: begin
        // On a tie the requester that was not served last wins.
        grant_a = a_valid && (!b_valid || last_grant == GRANT_B);
        grant_b = b_valid && !grant_a;
        a_ready = grant_a;
        b_ready = grant_b;
      end
      default: state_next = INIT;
    endcase
  end

  assign init_busy = (state == INIT);
  assign xfer      = grant_a || grant_b;
  assign xfer_addr = grant_a ? a_addr : b_addr;
  assign xfer_data = grant_a ? a_data : b_data;
  // %0 and %1 are not writable: only the upper address bits need checking.
  assign xfer_drop = (xfer_addr[registers_size-1:1] == '0);

  // Register-file drive, sweep pointer, grant history and drop counter.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      init_addr  <= FIRST_ADDR;
      last_grant <= GRANT_B;
      w          <= 1'b0;
      r_dest     <= '0;
      write_data <= '0;
      drop_count <= 8'd0;
    end else begin
      case (state)
        INIT: begin
          w          <= 1'b1;
          r_dest     <= init_addr;
          write_data <= '0;
          init_addr  <= init_addr + registers_size'(1);
        end
        ARB: begin
          if (xfer) begin
            last_grant <= grant_a ? GRANT_A : GRANT_B;
            if (xfer_drop) begin
              w <= 1'b0;
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else begin
              w          <= 1'b1;
              r_dest     <= xfer_addr;
              write_data <= xfer_data;
            end
          end else begin
            // Address and data hold; only the enable drops.
            w <= 1'b0;
          end
        end
        default: w <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset state, zero-fill sweep,
// single-requester write, contention, dropped writes, mid-sweep reset and
// drop-counter saturation. A small register-file model commits on w.
module tb_regfile_write_arbiter;

  localparam int N  = 8;
  localparam int RS = 3;

  logic          clk = 1'b0;
  logic          nReset;
  logic          a_valid, b_valid;
  logic [RS-1:0] a_addr, b_addr;
  logic [N-1:0]  a_data, b_data;
  logic          a_ready, b_ready;
  logic          w;
  logic [RS-1:0] r_dest;
  logic [N-1:0]  write_data;
  logic          init_busy;
  logic [7:0]    drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] rf [0:(1<<RS)-1];

  regfile_write_arbiter #(.n(N), .registers_size(RS)) dut (
    .clk(clk), .nReset(nReset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .w(w), .r_dest(r_dest), .write_data(write_data),
    .init_busy(init_busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Register-file model: commits the driven write on the rising edge.
  always @(posedge clk) begin
    if (w) rf[r_dest] <= write_data;
  end

  task automatic idle_inputs;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  // Checks the six-cycle sweep; caller has just released reset off-edge.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (w !== 1'b1 || r_dest !== RS'(i + 2) || write_data !== 8'd0) begin
        n_fail++;
        $display("FAIL %s_sweep[%0d]: got w=%b r_dest=%0d data=%0d, want w=1 r_dest=%0d data=0",
                 tag, i, w, r_dest, write_data, i + 2);
      end
      n_checks++;
      if (init_busy !== (i < 5)) begin
        n_fail++;
        $display("FAIL %s_busy[%0d]: got %b want %b", tag, i, init_busy, (i < 5));
      end
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    a_valid = 1'b1; a_addr = 3'd3; a_data = 8'd1;
    nReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (w !== 1'b0 || r_dest !== 3'd0 || write_data !== 8'd0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got w=%b r_dest=%0d data=%0d drops=%0d, want all 0",
               w, r_dest, write_data, drop_count);
    end
    n_checks++;
    if (init_busy !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b a_ready=%b b_ready=%b, want 1 0 0",
               init_busy, a_ready, b_ready);
    end
    @(negedge clk);
    nReset = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL init_no_ready: got a_ready=%b want 0", a_ready);
    end
    check_sweep("init");
    // A has been valid throughout; it is granted as soon as the sweep ends.
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_sweep_ready: got a_ready=%b want 1", a_ready);
    end
    idle_inputs();
    #1;
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: got a_ready=%b b_ready=%b want 0 0", a_ready, b_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (w !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_w: got w=%b want 0", w);
    end
  endtask

  task automatic test_contention;
    logic exp_a;
    a_valid = 1'b1; a_addr = 3'd2; a_data = 8'd11;
    b_valid = 1'b1; b_addr = 3'd4; b_data = 8'd24;
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      n_checks++;
      if (a_ready !== exp_a || b_ready !== !exp_a) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got a_ready=%b b_ready=%b want %b %b",
                 i, a_ready, b_ready, exp_a, !exp_a);
      end
      @(posedge clk); #1;
      n_checks++;
      if (w !== 1'b1 || r_dest !== (exp_a ? 3'd2 : 3'd4) ||
          write_data !== (exp_a ? 8'd11 : 8'd24)) begin
        n_fail++;
        $display("FAIL rr_write[%0d]: got w=%b r_dest=%0d data=%0d, want w=1 r_dest=%0d data=%0d",
                 i, w, r_dest, write_data, exp_a ? 2 : 4, exp_a ? 11 : 24);
      end
    end
    idle_inputs();
    @(posedge clk); #1;
    n_checks++;
    if (rf[2] !== 8'd11 || rf[4] !== 8'd24) begin
      n_fail++;
      $display("FAIL rr_readback: got r2=%0d r4=%0d want 11 24", rf[2], rf[4]);
    end
  endtask

  task automatic test_a_only;
    a_valid = 1'b1; a_addr = 3'd3; a_data = 8'd5;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL a_only_ready: got a_ready=%b b_ready=%b want 1 0", a_ready, b_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (w !== 1'b1 || r_dest !== 3'd3 || write_data !== 8'd5) begin
      n_fail++;
      $display("FAIL a_only_write: got w=%b r_dest=%0d data=%0d want 1 3 5", w, r_dest, write_data);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf[3] !== 8'd5) begin
      n_fail++;
      $display("FAIL a_only_readback: got %0d want 5", rf[3]);
    end
    // With no transfer only w drops; address and data hold.
    n_checks++;
    if (w !== 1'b0 || r_dest !== 3'd3 || write_data !== 8'd5) begin
      n_fail++;
      $display("FAIL a_only_hold: got w=%b r_dest=%0d data=%0d want 0 3 5", w, r_dest, write_data);
    end
  endtask

  task automatic test_drops;
    b_valid = 1'b1; b_addr = 3'd1; b_data = 8'd9;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drop1_ready: got b_ready=%b want 1", b_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (w !== 1'b0 || drop_count !== 8'd1) begin
      n_fail++;
      $display("FAIL drop1: got w=%b drops=%0d want 0 1", w, drop_count);
    end
    b_addr = 3'd0; b_data = 8'd7;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drop0_ready: got b_ready=%b want 1", b_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (w !== 1'b0 || drop_count !== 8'd2) begin
      n_fail++;
      $display("FAIL drop0: got w=%b drops=%0d want 0 2", w, drop_count);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf[1] !== 8'hA5 || rf[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL drop_readback: got r0=%h r1=%h want a5 a5", rf[0], rf[1]);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int guard;
    nReset = 1'b0;
    #3;
    @(negedge clk);
    nReset = 1'b1;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (r_dest !== 3'd5 && guard < 20);
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL mid_sweep_reach: r_dest never reached 5, got %0d", r_dest);
    end
    #2;
    nReset = 1'b0;
    #1;
    n_checks++;
    if (w !== 1'b0 || r_dest !== 3'd0 || init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_sweep_reset: got w=%b r_dest=%0d busy=%b want 0 0 1", w, r_dest, init_busy);
    end
    @(negedge clk);
    nReset = 1'b1;
    check_sweep("restart");
  endtask

  task automatic test_saturation;
    b_valid = 1'b1; b_addr = 3'd1; b_data = 8'd3;
    repeat (255) @(posedge clk);
    #1;
    n_checks++;
    if (drop_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_reach: got drops=%0d want 255", drop_count);
    end
    repeat (45) @(posedge clk);
    #1;
    n_checks++;
    if (drop_count !== 8'd255 || w !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hold: got drops=%0d w=%b want 255 0", drop_count, w);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < (1 << RS); i++) rf[i] = 8'hA5;
    test_reset();
    test_contention();
    test_a_only();
    test_drops();
    test_reset_mid_sweep();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
